// File: rtl/lab3_pkg.sv
// Shared types and default sizing for the round-robin register write arbiter.
package lab3_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/lab3_rr_picker.sv
// Combinational round-robin picker: first set candidate bit found circularly
// starting just above ptr, wrapping from N_REQ-1 back to 0.
module lab3_rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0] win_idx
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        pos        = '0;
        // Offsets 1..N_REQ so the pointer's own slot is examined last.
        for (int k = 1; k <= N_REQ; k++) begin
            pos = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && cand[pos]) begin
                found   = 1'b1;
                win_idx = pos;
            end
        end
        if (found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lab3_dff_reg_arbiter.sv
// Round-robin write arbiter in front of a shared WIDTH-bit register: one grant
// per cycle, the granted word is loaded on the edge that ends the grant cycle.
module lab3_dff_reg_arbiter
    import lab3_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [WIDTH-1:0] q_reg;
    logic             q_valid_reg;

    logic [N_REQ-1:0] cand;
    logic [PTR_W-1:0] search_ptr;
    logic [N_REQ-1:0] win_onehot;
    logic [PTR_W-1:0] win_idx;
    logic             load;

    logic [WIDTH-1:0] words [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
            assign words[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // During a grant the current winner becomes the new pointer on this edge,
    // so the follow-on search starts from it and excludes it.
    assign cand       = (state_reg == GRANT) ? (req & ~gnt_reg) : req;
    assign search_ptr = (state_reg == GRANT) ? gnt_idx_reg : ptr_reg;

    lab3_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .cand       (cand),
        .ptr        (search_ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        gnt_next     = '0;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|win_onehot) begin
                    state_next   = GRANT;
                    gnt_next     = win_onehot;
                    gnt_idx_next = win_idx;
                end
            end
            GRANT: begin
                load     = 1'b1;
                ptr_next = gnt_idx_reg;
                if (|win_onehot) begin
                    gnt_next     = win_onehot;
                    gnt_idx_next = win_idx;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= PTR_W'(N_REQ - 1);
            gnt_idx_reg <= '0;
            gnt_reg     <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            gnt_reg     <= gnt_next;
            if (load) begin
                q_reg       <= words[gnt_idx_reg];
                q_valid_reg <= 1'b1;
            end
        end
    end

    assign gnt     = gnt_reg;
    assign q       = q_reg;
    assign q_valid = q_valid_reg;
    assign busy    = (state_reg == GRANT);

endmodule

// File: tb/tb_lab3_dff_reg_arbiter.sv
// Directed plus randomized bench for the round-robin register write arbiter,
// checked every cycle against an integer-level reference model.
module tb_lab3_dff_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cur = requester holding the grant this cycle (-1 none).
    int           m_cur = -1;
    int           m_ptr = N - 1;
    logic [W-1:0] m_q   = '0;
    logic         m_qv  = 1'b0;

    lab3_dff_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] set, input int start);
        for (int k = 1; k <= N; k++) begin
            if (set[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] wd);
        logic [N-1:0] set;
        int           start;
        if (rst) begin
            m_cur = -1;
            m_ptr = N - 1;
            m_q   = '0;
            m_qv  = 1'b0;
        end else begin
            set   = r;
            start = m_ptr;
            if (m_cur >= 0) begin
                m_q        = wd[m_cur*W +: W];
                m_qv       = 1'b1;
                m_ptr      = m_cur;
                start      = m_cur;
                set[m_cur] = 1'b0;
            end
            m_cur = first_from(set, start);
        end
    endtask

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        return g;
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] wd);
        @(negedge clock);
        reset = rst;
        req   = r;
        wdata = wd;
        @(posedge clock);
        model_edge(rst, r, wd);
        #1;
        check("gnt", 32'(gnt), 32'(m_gnt()));
        check("q", 32'(q), 32'(m_q));
        check("q_valid", 32'(q_valid), 32'(m_qv));
        check("busy", 32'(busy), 32'(m_cur >= 0));
        $display("t=%0t rst=%b req=%b gnt=%b q=%h qv=%b busy=%b", $time, rst, r, gnt, q, q_valid, busy);
    endtask

    logic [N*W-1:0] seq_words;
    logic [N-1:0]   exp_seq [5];

    initial begin
        // Reset held two cycles while everyone requests.
        step(1'b1, 4'b1111, 32'h0);
        check("rst_q", 32'(q), 32'h0);
        step(1'b1, 4'b1111, 32'h0);
        check("rst_gnt", 32'(gnt), 32'h0);
        step(1'b0, 4'b1111, 32'h0);
        check("first_gnt", 32'(gnt), 32'b0001);

        // Sole requester: GRANT / IDLE alternation.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0010, 32'h0000_A500);
        check("single_gnt", 32'(gnt), 32'b0010);
        step(1'b0, 4'b0010, 32'h0000_A500);
        check("single_q", 32'(q), 32'hA5);
        check("single_idle", 32'(gnt), 32'h0);
        step(1'b0, 4'b0010, 32'h0000_A500);
        check("single_regnt", 32'(gnt), 32'b0010);
        step(1'b0, 4'b0000, 32'h0000_A500);

        // Full contention rotates with no bubbles.
        step(1'b1, 4'b0000, 32'h0);
        seq_words  = 32'h1312_1110;
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, seq_words);
            check("rr_gnt", 32'(gnt), 32'(exp_seq[i]));
            if (i > 0) check("rr_q", 32'(q), 32'(8'h10 + i - 1));
        end

        // Wrap from requester 3 back to 0, then to 3.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b1000, 32'h5500_0066);
        check("wrap_g3", 32'(gnt), 32'b1000);
        step(1'b0, 4'b1001, 32'h5500_0066);
        check("wrap_g0", 32'(gnt), 32'b0001);
        step(1'b0, 4'b1001, 32'h5500_0066);
        check("wrap_g3b", 32'(gnt), 32'b1000);
        step(1'b0, 4'b0000, 32'h5500_0066);

        // Withdrawal: requester 2 drops before ever being sampled in GRANT.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0101, 32'h0077_0088);
        check("wd_g0", 32'(gnt), 32'b0001);
        step(1'b0, 4'b0001, 32'h0077_0088);
        check("wd_q", 32'(q), 32'h88);
        check("wd_nogrant", 32'(gnt), 32'h0);
        step(1'b0, 4'b0000, 32'h0077_0088);
        check("wd_idle", 32'(gnt), 32'h0);

        // Reset on the edge that would load requester 2's word.
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0100, 32'h003C_0000);
        check("mid_g2", 32'(gnt), 32'b0100);
        step(1'b1, 4'b0101, 32'h003C_0000);
        check("mid_q", 32'(q), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b0101, 32'h003C_0000);
        check("mid_next", 32'(gnt), 32'b0001);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), N'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lab3_dff_reg_arbiter.md
# lab3_dff_reg_arbiter

Round-robin write arbiter for a shared W-bit D-register. Up to N_REQ requesters each present a request and a data word. The block grants one requester per cycle and loads that requester's word into the register on the rising clock edge that ends the grant cycle. It sits in front of the lab's positive-edge D-register storage and is the only path by which that storage is written.

## Interface
- N_REQ, default 4: number of requesters; minimum 2.
- WIDTH, default 8: width of the shared register and of each data word.
- PTR_W, default $clog2(N_REQ): width of the round-robin pointer; derived, not overridden.

- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req  in  N_REQ  per-requester write request; level, held until that requester sees its gnt bit.
- wdata  in  N_REQ*WIDTH  packed words; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  registered one-hot grant; all zero when idle.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  high once the register has been written at least once since reset.
- busy  out  1  high when state is GRANT.

## Operation
- States: IDLE, GRANT.
- IDLE: on an edge where req != 0, pick a winner, set gnt to the winner's one-hot and go to GRANT. On an edge where req == 0, stay in IDLE with gnt = 0.
- GRANT: on the edge ending the cycle, q <= wdata[winner], q_valid <= 1, and ptr <= winner.
  - Next pick is made from req & ~gnt, which excludes the current winner.
  - If that set is non-zero: stay in GRANT with the new one-hot gnt (back-to-back grants, no bubble).
  - If it is empty: go to IDLE with gnt = 0.
- Winner selection: the first set bit of the candidate set, searching circularly from ptr+1 upward with wrap from N_REQ-1 to 0.
- Handshake:
  - A requester sees gnt[i] = 1 for exactly one cycle per grant; its wdata must be stable during that cycle.
  - It drops req[i] in the cycle after gnt, or keeps it high to ask again.
  - A sole requester holding req high is re-granted every second cycle: GRANT, IDLE, GRANT, ...
- Withdrawal: a req bit that falls before it is sampled with a grant is never granted; no error is raised.
- req bits that change during the grant cycle do not affect the load already in progress.
- The register holds its value whenever gnt == 0.
- Reset, including mid-GRANT:
  - gnt = 0, q = 0, q_valid = 0, busy = 0, state = IDLE.
  - ptr = N_REQ-1, so requester 0 has top priority first.
  - The pending load is suppressed.
  - Reset has priority over every other event on the same edge.

## Timing
- Req to grant: req[i] sampled high on edge k (IDLE) gives gnt[i] = 1 during cycle k..k+1.
- Grant to data: q = wdata[i] and q_valid = 1 are visible after edge k+1.
- Request to data is therefore 2 edges.
- Maximum throughput: one write per cycle while two or more requesters stay active.
- All outputs come directly from flops; there is no combinational path from req or wdata to any output.
- busy == (gnt != 0) at all times.

## Structure
- Package lab3_pkg holds the state enum (IDLE, GRANT) and the default N_REQ and WIDTH constants.
- Sub-module lab3_rr_picker: combinational; inputs are the candidate vector and ptr; outputs are the one-hot winner and the winner index.
- Top level contains the FSM, ptr, gnt, q and q_valid flops.
- The register data path is a WIDTH-bit enable flop: load when state == GRANT.

## Test plan
All scenarios use N_REQ=4, WIDTH=8.
- Reset: reset = 1 for 2 cycles with req = 4'b1111 -> gnt = 0, q = 8'h00, q_valid = 0 throughout; the first grant after release is 4'b0001.
- Single requester: req = 4'b0010, wdata[1] = 8'hA5, held -> gnt = 4'b0010 one cycle after sampling; then q = 8'hA5, q_valid = 1; re-grant pattern GRANT/IDLE alternating.
- Full contention: req = 4'b1111 held, wdata[i] = 8'h10+i -> gnt sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles; q follows 8'h10..8'h13.
- Wrap and fairness: after a grant to requester 3, assert req = 4'b1001 -> next grant is 4'b0001, then 4'b1000.
- Withdrawal: req[2] high for 1 cycle while gnt = 4'b0001 and req = 4'b0101, then low before being sampled in GRANT -> requester 2 never granted; q unchanged from requester 0's word.
- Reset mid-grant: reset = 1 on the edge ending gnt = 4'b0100 with wdata[2] = 8'h3C -> q = 8'h00 (not 8'h3C), gnt = 0, state = IDLE; the next grant goes to the lowest-index active requester.
